// File: rtl/uart_rx_param_if.sv
// Receive-side bundle of uart_rx_param: output word register, its handshake and sideband flags.
// The receiver owns the master modport; the host-side consumer owns the slave modport.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_frame_err;
    logic                 o_parity_err;
    logic                 o_break;
    logic                 o_overrun;
    logic                 o_busy;

    // Handshake: a word transfers on any cycle where o_valid & i_ready.
    // o_data and the flags stay stable while o_valid is high.
    // o_valid does not depend on i_ready.
    modport master (
        output o_data, o_valid, o_frame_err, o_parity_err, o_break, o_overrun, o_busy,
        input  i_ready
    );

    modport slave (
        input  o_data, o_valid, o_frame_err, o_parity_err, o_break, o_overrun, o_busy,
        output i_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, optional parity, 1 or 2 checked stop bits.
// Each received word is held in a valid/ready output register with framing, parity, break and overrun flags.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    uart_rx_param_if.master  bus,
    output logic [2:0]       dbg_state
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_D  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_S  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5,
        S_WAIT   = 3'd6
    } state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s;
    logic [BW-1:0]        bcnt, bcnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_bit_n;
    logic                 ferr, ferr_n;
    logic                 any1, any1_n;
    logic                 done;
    logic                 perr_calc;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            bcnt    <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            ferr    <= 1'b0;
            any1    <= 1'b0;
        end else begin
            state   <= state_n;
            bcnt    <= bcnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par_bit <= par_bit_n;
            ferr    <= ferr_n;
            any1    <= any1_n;
        end
    end

    always_comb begin
        state_n   = state;
        bcnt_n    = bcnt + 1'b1;
        idx_n     = idx;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        ferr_n    = ferr;
        any1_n    = any1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                bcnt_n = '0;
                idx_n  = '0;
                if (!rx_s) begin
                    state_n = S_START;
                    ferr_n  = 1'b0;
                    any1_n  = 1'b0;
                end
            end
            // Re-check the start bit at its middle; from here on each sample lands mid-bit.
            S_START: begin
                if (bcnt == HALF_M1) begin
                    bcnt_n  = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bcnt == FULL_M1) begin
                    bcnt_n  = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    any1_n  = any1 | rx_s;
                    if (idx == LAST_D) begin
                        idx_n   = '0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bcnt == FULL_M1) begin
                    bcnt_n    = '0;
                    par_bit_n = rx_s;
                    any1_n    = any1 | rx_s;
                    state_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (bcnt == FULL_M1) begin
                    bcnt_n = '0;
                    ferr_n = ferr | ~rx_s;
                    any1_n = any1 | rx_s;
                    if (idx == LAST_S) begin
                        idx_n   = '0;
                        state_n = S_DONE;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                bcnt_n  = '0;
                state_n = ferr ? S_WAIT : S_IDLE;
            end
            // A held-low line (break) must go high before a new start bit is accepted.
            S_WAIT: begin
                bcnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                bcnt_n  = '0;
            end
        endcase
    end

    always_comb begin
        case (PARITY)
            1:       perr_calc = ~(^{shreg, par_bit});
            2:       perr_calc = ^{shreg, par_bit};
            default: perr_calc = 1'b0;
        endcase
    end

    // Output word register: a load may coincide with an accept; a frame arriving while the
    // previous word is still unaccepted is dropped and reported as overrun.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.o_data       <= '0;
            bus.o_valid      <= 1'b0;
            bus.o_frame_err  <= 1'b0;
            bus.o_parity_err <= 1'b0;
            bus.o_break      <= 1'b0;
            bus.o_overrun    <= 1'b0;
        end else begin
            bus.o_overrun <= 1'b0;
            if (done && (!bus.o_valid || bus.i_ready)) begin
                bus.o_data       <= shreg;
                bus.o_valid      <= 1'b1;
                bus.o_frame_err  <= ferr;
                bus.o_parity_err <= perr_calc;
                bus.o_break      <= ~any1;
            end else begin
                if (done) bus.o_overrun <= 1'b1;
                if (bus.o_valid && bus.i_ready) bus.o_valid <= 1'b0;
            end
        end
    end

    assign bus.o_busy = (state != S_IDLE);
    assign dbg_state  = state;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_param;
    localparam int CPB = 16;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd6;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [2:0] st_a, st_b, st_c;
    int n_assert = 0;
    int n_fail = 0;
    int ovr_a = 0, ovr_b = 0, ovr_c = 0;
    int base;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if_a ();
    uart_rx_param_if #(.DATA_BITS(8)) if_b ();
    uart_rx_param_if #(.DATA_BITS(8)) if_c ();

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rstn(rstn), .rx(rx_a), .bus(if_a), .dbg_state(st_a));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rstn(rstn), .rx(rx_b), .bus(if_b), .dbg_state(st_b));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rstn(rstn), .rx(rx_c), .bus(if_c), .dbg_state(st_c));

    logic [7:0] obs_data [3];
    logic       obs_valid [3];
    logic       obs_fe [3];
    logic       obs_pe [3];
    logic       obs_brk [3];
    logic       obs_busy [3];

    always_comb begin
        obs_data[0] = if_a.o_data;  obs_data[1] = if_b.o_data;  obs_data[2] = if_c.o_data;
        obs_valid[0] = if_a.o_valid; obs_valid[1] = if_b.o_valid; obs_valid[2] = if_c.o_valid;
        obs_fe[0] = if_a.o_frame_err; obs_fe[1] = if_b.o_frame_err; obs_fe[2] = if_c.o_frame_err;
        obs_pe[0] = if_a.o_parity_err; obs_pe[1] = if_b.o_parity_err; obs_pe[2] = if_c.o_parity_err;
        obs_brk[0] = if_a.o_break; obs_brk[1] = if_b.o_break; obs_brk[2] = if_c.o_break;
        obs_busy[0] = if_a.o_busy; obs_busy[1] = if_b.o_busy; obs_busy[2] = if_c.o_busy;
    end

    always @(posedge clk) begin
        if (if_a.o_overrun) ovr_a <= ovr_a + 1;
        if (if_b.o_overrun) ovr_b <= ovr_b + 1;
        if (if_c.o_overrun) ovr_c <= ovr_c + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic set_ready(input int sel, input logic v);
        case (sel)
            0:       if_a.i_ready = v;
            1:       if_b.i_ready = v;
            default: if_c.i_ready = v;
        endcase
    endtask

    // Drives start, 8 data bits LSB first, optional parity, then nstop stop bits.
    // The line is left at the level of the last stop bit.
    task automatic send_frame(input int sel, input logic [7:0] data, input bit par_en,
                              input logic par, input logic s1, input logic s2, input int nstop);
        logic [11:0] bits;
        int n;
        bits = '0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        n = 9;
        if (par_en) begin bits[n] = par; n++; end
        bits[n] = s1; n++;
        if (nstop == 2) begin bits[n] = s2; n++; end
        for (int i = 0; i < n; i++) begin
            set_rx(sel, bits[i]);
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int sel, input string tag);
        for (int i = 0; i < 400 && !obs_valid[sel]; i++) @(negedge clk);
        chk(tag, 32'(obs_valid[sel]), 32'd1);
    endtask

    task automatic accept(input int sel, input string tag);
        set_ready(sel, 1'b1);
        @(negedge clk);
        set_ready(sel, 1'b0);
        chk(tag, 32'(obs_valid[sel]), 32'd0);
    endtask

    initial begin
        if_a.i_ready = 1'b0;
        if_b.i_ready = 1'b0;
        if_c.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid_a", 32'(if_a.o_valid), 32'd0);
        chk("rst_data_a", 32'(if_a.o_data), 32'h00);
        chk("rst_flags_a", {29'd0, if_a.o_frame_err, if_a.o_parity_err, if_a.o_break}, 32'd0);
        chk("rst_busy_a", 32'(if_a.o_busy), 32'd0);
        chk("rst_overrun_a", 32'(if_a.o_overrun), 32'd0);
        chk("rst_valid_bc", {30'd0, if_b.o_valid, if_c.o_valid}, 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5, held until accepted
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        set_rx(0, 1'b1);
        wait_valid(0, "a5_valid");
        chk("a5_data", 32'(obs_data[0]), 32'hA5);
        chk("a5_flags", {29'd0, obs_fe[0], obs_pe[0], obs_brk[0]}, 32'd0);
        repeat (30) @(negedge clk);
        chk("a5_hold_valid", 32'(obs_valid[0]), 32'd1);
        chk("a5_hold_data", 32'(obs_data[0]), 32'hA5);
        accept(0, "a5_accept");

        // 8E1: 0x03 has even weight, so a parity bit of 1 is an error
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        set_rx(1, 1'b1);
        wait_valid(1, "e1_bad_valid");
        chk("e1_bad_data", 32'(obs_data[1]), 32'h03);
        chk("e1_bad_perr", 32'(obs_pe[1]), 32'd1);
        chk("e1_bad_ferr", 32'(obs_fe[1]), 32'd0);
        accept(1, "e1_bad_accept");
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        set_rx(1, 1'b1);
        wait_valid(1, "e1_ok_valid");
        chk("e1_ok_data", 32'(obs_data[1]), 32'h03);
        chk("e1_ok_perr", 32'(obs_pe[1]), 32'd0);
        accept(1, "e1_ok_accept");

        // 8N2 0x5A with second stop bit 0, line held low afterwards
        send_frame(2, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        wait_valid(2, "n2_valid");
        chk("n2_data", 32'(obs_data[2]), 32'h5A);
        chk("n2_ferr", 32'(obs_fe[2]), 32'd1);
        chk("n2_brk", 32'(obs_brk[2]), 32'd0);
        repeat (20) @(negedge clk);
        chk("n2_wait_state", 32'(st_c), 32'(ST_WAIT));
        set_rx(2, 1'b1);
        repeat (5) @(negedge clk);
        chk("n2_idle_state", 32'(st_c), 32'(ST_IDLE));
        accept(2, "n2_accept");

        // Break: line low for 12 bit-times gives exactly one frame
        base = ovr_a;
        set_rx(0, 1'b0);
        repeat (12 * CPB) @(negedge clk);
        chk("brk_valid", 32'(obs_valid[0]), 32'd1);
        chk("brk_data", 32'(obs_data[0]), 32'h00);
        chk("brk_flags", {30'd0, obs_brk[0], obs_fe[0]}, 32'd3);
        chk("brk_wait_state", 32'(st_a), 32'(ST_WAIT));
        set_rx(0, 1'b1);
        repeat (200) @(negedge clk);
        chk("brk_no_overrun", 32'(ovr_a - base), 32'd0);
        accept(0, "brk_accept");
        repeat (50) @(negedge clk);
        chk("brk_single_frame", 32'(obs_valid[0]), 32'd0);

        // Overrun: 0x11 unaccepted, then 0x22 is dropped
        base = ovr_a;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        set_rx(0, 1'b1);
        wait_valid(0, "ovr_first_valid");
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        set_rx(0, 1'b1);
        repeat (40) @(negedge clk);
        chk("ovr_data_kept", 32'(obs_data[0]), 32'h11);
        chk("ovr_pulse_count", 32'(ovr_a - base), 32'd1);
        chk("ovr_still_valid", 32'(obs_valid[0]), 32'd1);
        accept(0, "ovr_accept");

        // Short low glitch is rejected at the start-bit midpoint
        set_rx(0, 1'b0);
        repeat (CPB / 4) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (40) @(negedge clk);
        chk("glitch_valid", 32'(obs_valid[0]), 32'd0);
        chk("glitch_busy", 32'(obs_busy[0]), 32'd0);

        // Reset mid-frame with a word pending
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        set_rx(0, 1'b1);
        wait_valid(0, "mid_pending_valid");
        set_rx(0, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        chk("mid_busy", 32'(obs_busy[0]), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(obs_valid[0]), 32'd0);
        chk("mid_rst_data", 32'(obs_data[0]), 32'h00);
        chk("mid_rst_busy", 32'(obs_busy[0]), 32'd0);
        chk("mid_rst_state", 32'(st_a), 32'(ST_IDLE));
        set_rx(0, 1'b1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (50) @(negedge clk);
        chk("post_rst_valid", 32'(obs_valid[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
